// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prio_pkg
// Purpose : Shared definitions for the priority arbiter. It holds the FSM
//           state encoding and a constant-evaluable clog2 helper that sizes
//           the index ports.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package prio_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Ceiling log2. It is used for elaboration-time widths only.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prio_find.sv
`default_nettype none
// ============================================================================
// Module  : prio_find
// Purpose : Combinational descending search with wrap-around. The search
//           starts at index `start`, moves down toward 0, and then wraps to
//           N-1. It reports the first set bit of `req` that it meets.
// Ports   : req   [N-1:0] in  - candidate request vector
//           start [W-1:0] in  - first index examined
//           found         out - at least one bit of req is set
//           idx   [W-1:0] out - index of the first set bit in search order
// Revision: 1.0 - initial release
// ============================================================================
module prio_find
   import prio_pkg::*;
#(
   parameter int N = 16,
   localparam int W = clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   // The loop walks from the farthest offset to the nearest one. Each hit
   // overwrites the previous result, so the bit nearest to `start` in
   // descending order wins.
   always_comb begin
      int pos;
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int off = N - 1; off >= 0; off--) begin
         pos = int'(start) - off;
         if (pos < 0) begin
            pos = pos + N;
         end
         if (req[pos]) begin
            found = 1'b1;
            idx   = W'(pos);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : prio_arbiter
// Purpose : N-way request arbiter with registered one-hot grant. In fixed
//           mode the highest index wins. In round-robin mode the search
//           starts just below the previous grantee and wraps. A grant is
//           held until `done`. On `done` it can pass directly to the next
//           requester with no idle cycle.
// Ports   : clk                in  - rising-edge clock
//           rst_n              in  - asynchronous active-low reset
//           en                 in  - arbitration enable (low blocks new grants)
//           req       [N-1:0]  in  - request vector
//           done               in  - current grantee releases the grant
//           grant     [N-1:0]  out - registered one-hot grant
//           gnt_idx   [W-1:0]  out - registered binary index of the grant
//           gnt_valid          out - a grant is held
// Revision: 1.0 - initial release
// ============================================================================
module prio_arbiter
   import prio_pkg::*;
#(
   parameter int N       = 16,
   parameter int RR_MODE = 0,
   localparam int W      = clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   state_e         state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [W-1:0]   gnt_idx_q, gnt_idx_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic [W-1:0]   last_q, last_d;

   logic [W-1:0]   w_start;
   logic           w_found;
   logic [W-1:0]   w_idx;
   logic [N-1:0]   w_onehot;

   // Search origin. In round-robin mode the search starts one below the
   // previous grantee. The releasing requester is then examined last, which
   // gives it the lowest rank.
   generate
      if (RR_MODE != 0) begin : g_rr_start
         assign w_start = (last_q == '0) ? W'(N - 1) : (last_q - W'(1));
      end else begin : g_fixed_start
         assign w_start = W'(N - 1);
      end
   endgenerate

   prio_find #(
      .N     (N)
   ) u_find (
      .req   (req),
      .start (w_start),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_onehot = N'(1) << w_idx;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      last_d      = last_q;

      case (state_q)
         IDLE: begin
            // done is ignored here; only a new request can move the FSM.
            if (en && w_found) begin
               state_d     = GRANT;
               grant_d     = w_onehot;
               gnt_idx_d   = w_idx;
               gnt_valid_d = 1'b1;
               if (RR_MODE != 0) begin
                  last_d = w_idx;
               end
            end
         end
         GRANT: begin
            // req and en are not examined until done. Outputs come straight
            // from the flops, so unknown request bits cannot reach them.
            if (done) begin
               if (en && w_found) begin
                  grant_d     = w_onehot;
                  gnt_idx_d   = w_idx;
                  gnt_valid_d = 1'b1;
                  if (RR_MODE != 0) begin
                     last_d = w_idx;
                  end
               end else begin
                  state_d     = IDLE;
                  grant_d     = '0;
                  gnt_idx_d   = '0;
                  gnt_valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         last_q      <= last_d;
      end
   end

   assign grant     = grant_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_prio_arbiter
// Purpose : Self-checking bench. A fixed-priority instance and a round-robin
//           instance are driven with the same stimulus. Expected outputs come
//           from a request-level reference model. Each stimulus cycle queues
//           its expected outputs, and a monitor compares them after the next
//           rising edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prio_arbiter;
   import prio_pkg::*;

   localparam int N = 16;
   localparam int W = clog2(N);

   typedef struct packed {
      logic [N-1:0] g;
      logic [W-1:0] i;
      logic         v;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] grant_f, grant_r;
   logic [W-1:0] idx_f, idx_r;
   logic         valid_f, valid_r;

   int checks   = 0;
   int failures = 0;

   exp_t q_exp [2][$];

   // Reference state, indexed by mode: 0 = fixed, 1 = round-robin.
   bit m_valid [2];
   int m_idx   [2];
   int m_last  [2];

   prio_arbiter #(.N(N), .RR_MODE(0)) u_fixed (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
      .grant(grant_f), .gnt_idx(idx_f), .gnt_valid(valid_f)
   );

   prio_arbiter #(.N(N), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
      .grant(grant_r), .gnt_idx(idx_r), .gnt_valid(valid_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Fixed mode: the highest set bit wins. Round-robin mode: indices
   // last-1, last-2, ... are tried with wrap, and last itself comes last.
   function automatic int pick(input int m, input logic [N-1:0] r, input int last);
      if (m == 0) begin
         for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int i;
            i = (last - k + N) % N;
            if (r[i]) return i;
         end
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 1'b0;
         m_idx[m]   = 0;
         m_last[m]  = 0;
      end
   endtask

   task automatic model_step(input logic e, input logic [N-1:0] r, input logic d);
      for (int m = 0; m < 2; m++) begin
         exp_t x;
         int   w;
         w = pick(m, r, m_last[m]);
         if (!m_valid[m] || d) begin
            if (e && w >= 0) begin
               m_valid[m] = 1'b1;
               m_idx[m]   = w;
               if (m == 1) m_last[m] = w;
            end else if (m_valid[m]) begin
               m_valid[m] = 1'b0;
               m_idx[m]   = 0;
            end
         end
         x.v = m_valid[m];
         x.i = m_valid[m] ? W'(m_idx[m]) : '0;
         x.g = m_valid[m] ? (N'(1) << m_idx[m]) : '0;
         q_exp[m].push_back(x);
      end
   endtask

   // Drive at the falling edge and queue the outputs expected after the
   // next rising edge.
   task automatic drive_cycle(input logic e, input logic [N-1:0] r, input logic d);
      en   = e;
      req  = r;
      done = d;
      model_step(e, r, d);
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_grant_fx"}, grant_f, '0);
      chk({tag, "_valid_fx"}, valid_f, 1'b0);
      chk({tag, "_grant_rr"}, grant_r, '0);
      chk({tag, "_valid_rr"}, valid_r, 1'b0);
   endtask

   // Monitor: compare queued expectations after each rising edge and check
   // the grant/index consistency of both instances on every cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_exp[0].size() > 0) begin
            exp_t x;
            x = q_exp[0].pop_front();
            chk("grant_fx", grant_f, x.g);
            chk("idx_fx", idx_f, x.i);
            chk("valid_fx", valid_f, x.v);
         end
         if (q_exp[1].size() > 0) begin
            exp_t x;
            x = q_exp[1].pop_front();
            chk("grant_rr", grant_r, x.g);
            chk("idx_rr", idx_r, x.i);
            chk("valid_rr", valid_r, x.v);
         end
         chk("onehot_fx", grant_f, valid_f ? (N'(1) << idx_f) : '0);
         chk("onehot_rr", grant_r, valid_r ? (N'(1) << idx_r) : '0);
      end
   end

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      req   = '0;
      done  = 1'b0;
      model_reset();
      #1 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Both ends of the vector are requested; bit 15 wins in both modes.
      drive_cycle(1'b1, 16'h8001, 1'b0);
      drive_cycle(1'b1, 16'h8001, 1'b0);
      drive_cycle(1'b0, 16'h0000, 1'b1);

      // A held grant ignores request changes until done.
      repeat (5) drive_cycle(1'b1, 16'h0041, 1'b0);
      repeat (2) drive_cycle(1'b1, 16'h0001, 1'b0);
      drive_cycle(1'b1, 16'h0001, 1'b1);
      drive_cycle(1'b1, 16'h0001, 1'b0);
      drive_cycle(1'b0, 16'h0000, 1'b1);

      // Asynchronous reset mid-grant, then the round-robin search restarts at 15.
      drive_cycle(1'b1, 16'h0041, 1'b0);
      drive_cycle(1'b1, 16'h0041, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      @(negedge clk);
      check_zero("rst_held");
      rst_n = 1'b1;

      // Round-robin rotation over bits 8, 4 and 0 with done every second cycle.
      drive_cycle(1'b1, 16'h0111, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive_cycle(1'b1, 16'h0111, 1'b1);
         drive_cycle(1'b1, 16'h0111, 1'b0);
      end
      drive_cycle(1'b0, 16'h0000, 1'b1);

      // Enable gating.
      repeat (3) drive_cycle(1'b0, 16'hFFFF, 1'b0);
      drive_cycle(1'b1, 16'hFFFF, 1'b0);
      drive_cycle(1'b1, 16'hFFFF, 1'b1);
      drive_cycle(1'b0, 16'hFFFF, 1'b1);

      // done while idle.
      repeat (3) drive_cycle(1'b1, 16'h0000, 1'b1);

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         logic [N-1:0] r;
         r = N'($urandom & $urandom);
         if ($urandom_range(0, 9) == 0) r = '0;
         drive_cycle($urandom_range(0, 7) != 0, r, $urandom_range(0, 2) == 0);
      end

      drive_cycle(1'b0, 16'h0000, 1'b1);
      drive_cycle(1'b0, 16'h0000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
